// File: rtl/controlador_entrada_br_if.sv
// Register-bank write arbitration bus between CPU and the INPUT controller.
// Master drives CPU/decoder requests and the button; slave drives write-back.
interface controlador_entrada_br_if;
    logic       escreve_cpu;
    logic [4:0] reg_cpu;
    logic [1:0] sel_cpu;
    logic       inicia_entrada;
    logic [4:0] reg_entrada;
    logic       botao_entrada;
    logic       escreve_br;
    logic [4:0] reg_escrita;
    logic [1:0] ctrl_mux_escrita_br;
    logic       parar_cpu;
    logic       aguardando;

    modport master (
        output escreve_cpu, reg_cpu, sel_cpu,
        output inicia_entrada, reg_entrada, botao_entrada,
        input  escreve_br, reg_escrita, ctrl_mux_escrita_br,
        input  parar_cpu, aguardando
    );

    modport slave (
        input  escreve_cpu, reg_cpu, sel_cpu,
        input  inicia_entrada, reg_entrada, botao_entrada,
        output escreve_br, reg_escrita, ctrl_mux_escrita_br,
        output parar_cpu, aguardando
    );
endinterface

// File: rtl/controlador_entrada_br.sv
// INPUT instruction controller: stalls the CPU until a debounced button
// press, then writes the INPUT destination register through the bank mux.
module controlador_entrada_br #(
    parameter int DEBOUNCE_CICLOS = 16
) (
    input logic                     clock,
    input logic                     reset,
    controlador_entrada_br_if.slave bus
);

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_SOLTAR,
        ESPERA_BOTAO,
        DEBOUNCE,
        ESCREVE
    } estado_t;

    localparam logic [15:0] LIMITE = 16'(DEBOUNCE_CICLOS - 1);

    estado_t     estado;
    estado_t     prox;
    logic        sinc1;
    logic        botao_s;
    logic [15:0] cont;
    logic [15:0] cont_prox;
    logic [4:0]  reg_lat;
    logic [4:0]  reg_prox;

    logic        escreve;
    logic [4:0]  endereco;
    logic [1:0]  mux;
    logic        parar;
    logic        aguard;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1   <= 1'b0;
            botao_s <= 1'b0;
        end else begin
            sinc1   <= bus.botao_entrada;
            botao_s <= sinc1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= OCIOSO;
            cont    <= 16'd0;
            reg_lat <= 5'd0;
        end else begin
            estado  <= prox;
            cont    <= cont_prox;
            reg_lat <= reg_prox;
        end
    end

    always_comb begin
        prox      = estado;
        cont_prox = cont;
        reg_prox  = reg_lat;
        escreve   = 1'b0;
        endereco  = 5'd0;
        mux       = 2'b00;
        parar     = 1'b0;
        aguard    = 1'b0;
        unique case (estado)
            OCIOSO: begin
                escreve  = bus.escreve_cpu && (bus.reg_cpu != 5'd0);
                endereco = bus.reg_cpu;
                mux      = bus.sel_cpu;
                if (bus.inicia_entrada) begin
                    parar    = 1'b1;
                    reg_prox = bus.reg_entrada;
                    prox     = botao_s ? ESPERA_SOLTAR : ESPERA_BOTAO;
                end
            end
            ESPERA_SOLTAR: begin
                parar  = 1'b1;
                aguard = 1'b1;
                if (!botao_s)
                    prox = ESPERA_BOTAO;
            end
            ESPERA_BOTAO: begin
                parar  = 1'b1;
                aguard = 1'b1;
                if (botao_s) begin
                    prox      = DEBOUNCE;
                    cont_prox = 16'd0;
                end
            end
            DEBOUNCE: begin
                parar  = 1'b1;
                aguard = 1'b1;
                // Any glitch low restarts the full debounce window
                if (!botao_s) begin
                    prox      = ESPERA_BOTAO;
                    cont_prox = 16'd0;
                end else if (cont == LIMITE) begin
                    prox      = ESCREVE;
                    cont_prox = 16'd0;
                end else begin
                    cont_prox = cont + 16'd1;
                end
            end
            ESCREVE: begin
                escreve  = reg_lat != 5'd0;
                endereco = reg_lat;
                mux      = 2'b10;
                prox     = OCIOSO;
            end
            default: prox = OCIOSO;
        endcase
    end

    assign bus.escreve_br          = escreve;
    assign bus.reg_escrita         = endereco;
    assign bus.ctrl_mux_escrita_br = mux;
    assign bus.parar_cpu           = parar;
    assign bus.aguardando          = aguard;

endmodule

// File: tb/tb_controlador_entrada_br.sv
// Randomized and directed checks of the INPUT controller against a
// run-length reference model of the debounced button.
module tb_controlador_entrada_br;

    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    controlador_entrada_br_if bus ();

    controlador_entrada_br #(.DEBOUNCE_CICLOS(D)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference model: waiting flag, "button seen low" flag, high run length
    logic       m_wait;
    logic       m_armed;
    int         m_run;
    logic       m_write;
    logic [4:0] m_reg;
    logic       amostra [0:1];
    logic       obs_we;
    int         writes_seen;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_wait     = 1'b0;
        m_armed    = 1'b0;
        m_run      = 0;
        m_write    = 1'b0;
        m_reg      = 5'd0;
        amostra[0] = 1'b0;
        amostra[1] = 1'b0;
    endtask

    task automatic cpu_idle();
        bus.escreve_cpu    = 1'b0;
        bus.reg_cpu        = 5'd0;
        bus.sel_cpu        = 2'b00;
        bus.inicia_entrada = 1'b0;
        bus.reg_entrada    = 5'd0;
    endtask

    task automatic do_reset();
        cpu_idle();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_aguard", 8'(bus.aguardando), 8'd0);
        chk("rst_parar", 8'(bus.parar_cpu), 8'd0);
        chk("rst_we", 8'(bus.escreve_br), 8'd0);
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic passo();
        logic       bs;
        logic       ew;
        logic [4:0] ea;
        logic [1:0] em;
        logic       ep;
        logic       eg;
        @(negedge clock);
        bs = amostra[1];
        ew = 1'b0; ea = 5'd0; em = 2'b00; ep = 1'b0; eg = 1'b0;
        if (m_write) begin
            ew = m_reg != 5'd0;
            ea = m_reg;
            em = 2'b10;
        end else if (m_wait) begin
            ep = 1'b1;
            eg = 1'b1;
        end else begin
            ew = bus.escreve_cpu && bus.reg_cpu != 5'd0;
            ea = bus.reg_cpu;
            em = bus.sel_cpu;
            ep = bus.inicia_entrada;
        end
        obs_we = bus.escreve_br;
        if (m_write && ew) writes_seen++;
        chk("we", 8'(bus.escreve_br), 8'(ew));
        chk("addr", 8'(bus.reg_escrita), 8'(ea));
        chk("mux", 8'(bus.ctrl_mux_escrita_br), 8'(em));
        chk("parar", 8'(bus.parar_cpu), 8'(ep));
        chk("aguard", 8'(bus.aguardando), 8'(eg));
        if (m_write) begin
            m_write = 1'b0;
        end else if (m_wait) begin
            if (!m_armed) begin
                if (!bs) m_armed = 1'b1;
            end else if (bs) begin
                m_run++;
                // one detect cycle plus D debounce cycles
                if (m_run == D + 1) begin
                    m_wait  = 1'b0;
                    m_write = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end else if (bus.inicia_entrada) begin
            m_wait  = 1'b1;
            m_reg   = bus.reg_entrada;
            m_armed = !bs;
            m_run   = 0;
        end
        amostra[1] = amostra[0];
        amostra[0] = bus.botao_entrada;
        @(posedge clock);
        #1;
    endtask

    task automatic iniciar(logic [4:0] r);
        bus.inicia_entrada = 1'b1;
        bus.reg_entrada    = r;
        passo();
        cpu_idle();
    endtask

    task automatic segura(logic b, int n);
        bus.botao_entrada = b;
        for (int i = 0; i < n; i++) passo();
    endtask

    initial begin
        int lat;
        int inicio;
        writes_seen = 0;
        obs_we = 1'b0;
        bus.botao_entrada = 1'b0;
        model_clear();
        do_reset();

        // zero-latency CPU pass-through
        bus.escreve_cpu = 1'b1;
        bus.reg_cpu     = 5'd7;
        bus.sel_cpu     = 2'b01;
        passo();
        chk("pass_we", 8'(obs_we), 8'd1);
        cpu_idle();

        // clean press latency
        iniciar(5'd9);
        segura(1'b0, 2);
        bus.botao_entrada = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            passo();
            if (obs_we) lat = i;
        end
        chk("latency", 8'(lat), 8'd8);
        segura(1'b0, 2);

        // short press rejected, then clean press
        inicio = writes_seen;
        iniciar(5'd3);
        segura(1'b1, 3);
        segura(1'b0, 3);
        chk("short_nowrite", 8'(writes_seen - inicio), 8'd0);
        segura(1'b1, 10);
        chk("long_write", 8'(writes_seen - inicio), 8'd1);
        segura(1'b0, 3);

        // button held at start must be released first
        inicio = writes_seen;
        bus.botao_entrada = 1'b1;
        segura(1'b1, 3);
        iniciar(5'd12);
        segura(1'b1, 12);
        chk("held_nowrite", 8'(writes_seen - inicio), 8'd0);
        segura(1'b0, 2);
        segura(1'b1, 10);
        chk("held_write", 8'(writes_seen - inicio), 8'd1);
        segura(1'b0, 3);

        // register zero never written, either source
        iniciar(5'd0);
        segura(1'b1, 10);
        segura(1'b0, 2);
        bus.escreve_cpu = 1'b1;
        bus.reg_cpu     = 5'd0;
        bus.sel_cpu     = 2'b11;
        passo();
        cpu_idle();

        // reset during debounce abandons the INPUT
        iniciar(5'd20);
        segura(1'b1, 4);
        do_reset();
        bus.botao_entrada = 1'b0;
        segura(1'b0, 3);
        bus.escreve_cpu = 1'b1;
        bus.reg_cpu     = 5'd7;
        bus.sel_cpu     = 2'b01;
        passo();
        chk("post_rst_pass", 8'(obs_we), 8'd1);
        cpu_idle();

        // randomized traffic
        for (int blk = 0; blk < 500; blk++) begin
            int n;
            bus.botao_entrada = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 8);
            for (int c = 0; c < n; c++) begin
                bus.escreve_cpu    = 1'($urandom_range(0, 1));
                bus.reg_cpu        = ($urandom_range(0, 3) == 0)
                                     ? 5'd0 : 5'($urandom);
                bus.sel_cpu        = ($urandom_range(0, 2) == 2)
                                     ? 2'b11 : 2'($urandom_range(0, 1));
                bus.inicia_entrada = ($urandom_range(0, 7) == 0);
                bus.reg_entrada    = ($urandom_range(0, 3) == 0)
                                     ? 5'd0 : 5'($urandom);
                passo();
            end
            if ($urandom_range(0, 60) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controlador_entrada_br.md
CONTROLADOR_ENTRADA_BR -- requirements
Module: controlador_entrada_br

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CICLOS, default 16, meaning consecutive synchronized-high cycles required to accept the button (legal range 1..65535).
REQ-002 The block SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port escreve_cpu  input  1  CPU register-bank write request, current cycle.
REQ-005 The block SHALL have port reg_cpu  input  5  CPU destination register.
REQ-006 The block SHALL have port sel_cpu  input  2  CPU write-source select (00 ULA, 01 MEM_DADOS, 11 JAL/EXEC/BLOCK).
REQ-007 The block SHALL have port inicia_entrada  input  1  decoder flag: current instruction is INPUT.
REQ-008 The block SHALL have port reg_entrada  input  5  INPUT destination register.
REQ-009 The block SHALL have port botao_entrada  input  1  asynchronous user confirm button, active-high.
REQ-010 The block SHALL have port escreve_br  output  1  register-bank write enable.
REQ-011 The block SHALL have port reg_escrita  output  5  register-bank write address.
REQ-012 The block SHALL have port ctrl_mux_escrita_br  output  2  write-back mux select.
REQ-013 The block SHALL have port parar_cpu  output  1  PC/CPU stall, high holds the current instruction.
REQ-014 The block SHALL have port aguardando  output  1  user-visible "awaiting input" indicator.

Function
REQ-015 botao_entrada SHALL pass a 2-flop synchronizer; only its output (botao_s) is used internally.
REQ-016 FSM states SHALL be OCIOSO, ESPERA_SOLTAR, ESPERA_BOTAO, DEBOUNCE, ESCREVE.
REQ-017 OCIOSO: escreve_br = escreve_cpu and (reg_cpu != 0); reg_escrita = reg_cpu; ctrl_mux_escrita_br = sel_cpu; all combinational, zero latency.
REQ-018 OCIOSO with inicia_entrada=1: latch reg_entrada; next state ESPERA_SOLTAR if botao_s=1, else ESPERA_BOTAO; parar_cpu SHALL be 1 combinationally in that same cycle.
REQ-019 ESPERA_SOLTAR: remain until botao_s=0, then ESPERA_BOTAO (a button already held at INPUT start is never accepted).
REQ-020 ESPERA_BOTAO: on botao_s=1 go to DEBOUNCE with counter cleared.
REQ-021 DEBOUNCE: counter increments each cycle botao_s=1; botao_s=0 SHALL return to ESPERA_BOTAO and clear counter; when botao_s=1 and counter = DEBOUNCE_CICLOS-1, go to ESCREVE (exactly DEBOUNCE_CICLOS cycles spent in DEBOUNCE).
REQ-022 ESCREVE lasts exactly one cycle: escreve_br = (latched reg != 0), reg_escrita = latched reg, ctrl_mux_escrita_br = 10, parar_cpu = 0 (PC advances past INPUT on this edge); next state OCIOSO.
REQ-023 parar_cpu SHALL be 1 in ESPERA_SOLTAR, ESPERA_BOTAO, DEBOUNCE; 0 in ESCREVE and in OCIOSO unless REQ-018 applies.
REQ-024 aguardando SHALL be 1 in ESPERA_SOLTAR, ESPERA_BOTAO, DEBOUNCE, else 0.
REQ-025 In every state other than OCIOSO, escreve_cpu, reg_cpu, sel_cpu, inicia_entrada SHALL be ignored; escreve_br=0 outside OCIOSO/ESCREVE.
REQ-026 Simultaneous escreve_cpu and inicia_entrada in OCIOSO: CPU write SHALL still be forwarded that cycle per REQ-017.
REQ-027 Writes to register 0 SHALL never assert escreve_br, from either source.
REQ-028 Outside OCIOSO/ESCREVE, reg_escrita and ctrl_mux_escrita_br SHALL be 0.

Reset
REQ-029 reset=0 SHALL asynchronously force state OCIOSO, counter 0, synchronizer flops 0, latched register 0; aguardando=0, and parar_cpu/escreve_br follow REQ-017/REQ-023 from OCIOSO.
REQ-030 Reset asserted mid-wait SHALL abandon the INPUT with no register write; after release, a new inicia_entrada is required.

Verification (DEBOUNCE_CICLOS=4)
REQ-031 OCIOSO, escreve_cpu=1, reg_cpu=7, sel_cpu=01 -> same cycle escreve_br=1, reg_escrita=7, ctrl_mux=01, parar_cpu=0.
REQ-032 inicia_entrada=1, reg_entrada=9, button low; button rises at cycle N -> DEBOUNCE entered N+2, ESCREVE at N+6 with escreve_br=1, reg_escrita=9, ctrl_mux=10, parar_cpu=0; parar_cpu=1 every cycle before.
REQ-033 Button high 3 cycles then low during DEBOUNCE -> no write, back to ESPERA_BOTAO, parar_cpu stays 1; next clean 4-cycle press writes.
REQ-034 Button already held at inicia_entrada -> ESPERA_SOLTAR; no write until released then pressed ≥4 synchronized cycles.
REQ-035 reg_entrada=0 completed press, and escreve_cpu=1 reg_cpu=0 -> escreve_br never 1; FSM returns to OCIOSO.
REQ-036 reset=0 asserted in DEBOUNCE -> immediately aguardando=0, parar_cpu=0, no write; after release, idle pass-through resumes.
